// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder and its 4-bit carry-lookahead slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding (2-bit binary) and the slice width.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : nibble_adder_pkg

// File: rtl/cla_nibble_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
// Latency: 0 cycles (combinational).
// Backpressure: none.
// Ports: X, Y  nibble addends; Cin carry-in; S nibble sum;
//        C3 carry into bit 3 (for signed overflow); Cout carry out of bit 3.
import nibble_adder_pkg::*;

module cla_nibble_slice (
  input  logic [NIBBLE_W-1:0] X,
  input  logic [NIBBLE_W-1:0] Y,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] S,
  output logic                C3,
  output logic                Cout
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = X & Y;
  assign p = X ^ Y;

  // Flattened lookahead equations: every carry is a two-level function of
  // the generate/propagate terms and Cin, with no ripple through c[i-1].
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign S    = p ^ c[NIBBLE_W-1:0];
  assign C3   = c[3];
  assign Cout = c[4];

endmodule : cla_nibble_slice

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single 4-bit CLA slice.
// Latency: Start accepted at edge E0 -> Done high in the cycle after E(NIBBLES); issue interval NIBBLES+2.
// Backpressure: Ready is high only in IDLE; Start while Ready=0 is ignored.
// Ports: Clk, Reset_n (synchronous, active-low); Start/X/Y/Cin request (sampled on the accepting edge);
//        Ready, Done (one-cycle pulse), S/Cout/Overflow (held until the next completion).
// Optional: define SERIAL_ADDER_SUB_EN to add the Sub input (Sub=1 computes X-Y; Cout=1 means no borrow).
// WIDTH must be a multiple of 4 and at least 4.
import nibble_adder_pkg::*;

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Overflow
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  // Keep at least one counter bit so the WIDTH=4 build still elaborates.
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] x_nib, y_nib, s_nib;
  logic                slice_c3, slice_cout;
  logic                sub_req;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_req = Sub;
`else
  assign sub_req = 1'b0;
`endif

  cla_nibble_slice u_slice (
    .X    (x_nib),
    .Y    (y_nib),
    .Cin  (carry_q),
    .S    (s_nib),
    .C3   (slice_c3),
    .Cout (slice_cout)
  );

  // Select the operand nibble addressed by the counter.
  always_comb begin
    x_nib = '0;
    y_nib = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        x_nib = x_q[k*NIBBLE_W +: NIBBLE_W];
        y_nib = y_q[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          x_d     = X;
          // Subtraction is X + ~Y + 1: invert B and force the initial carry.
          y_d     = sub_req ? ~Y : Y;
          carry_d = sub_req ? 1'b1 : Cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < NIBBLES; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            sum_d[k*NIBBLE_W +: NIBBLE_W] = s_nib;
          end
        end
        carry_d = slice_cout;
        if (cnt_q == LAST_NIB) begin
          // Publish on the completion edge only; outputs hold otherwise.
          s_d     = sum_d;
          cout_d  = slice_cout;
          ovf_d   = slice_c3 ^ slice_cout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Ready    = (state_q == ST_IDLE);
  assign Done     = (state_q == ST_DONE);
  assign S        = s_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
// Latency: n/a.
// Backpressure: n/a.
module tb_nibble_serial_adder;

  localparam int W       = 16;
  localparam int NIB     = W / 4;
  localparam int MAX_LAT = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x, y;
  logic         cin;
  logic         sub;
  logic         ready, done, cout, ovf;
  logic [W-1:0] s;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .Start    (start),
    .X        (x),
    .Y        (y),
    .Cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub      (sub),
`endif
    .Ready    (ready),
    .Done     (done),
    .S        (s),
    .Cout     (cout),
    .Overflow (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic. Returns {overflow, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   r;
    logic         v;
    bb = sb ? ~b : b;
    c0 = sb ? 1'b1 : ci;
    r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    v  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return {v, r};
  endfunction

  // Waits for Done, sampling 1 time unit after each rising edge.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < MAX_LAT);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ci, input logic sb);
    logic [W+1:0] e;
    e = model(a, b, ci, sb);
    chk({tag, ".S"},    32'(s),    32'(e[W-1:0]));
    chk({tag, ".Cout"}, 32'(cout), 32'(e[W]));
    chk({tag, ".Ovf"},  32'(ovf),  32'(e[W+1]));
  endtask

  // One complete operation from IDLE; operands are scrambled during RUN.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb);
    int lat;
    @(negedge clk);
    x = a; y = b; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = W'($urandom); y = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk({tag, ".busy"}, 32'(ready), 32'd0);
    wait_done(lat);
    chk({tag, ".lat"}, 32'(lat), 32'(NIB));
    check_result(tag, a, b, ci, sb);
    @(posedge clk); #1;
    chk({tag, ".done_drop"}, 32'(done), 32'd0);
    chk({tag, ".ready_back"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int           lat;
    int           seen;
    logic [W-1:0] a, b, hold_s;
    logic [W+1:0] e;

    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.Ready", 32'(ready), 32'd1);
    chk("rst.Done",  32'(done),  32'd0);
    chk("rst.S",     32'(s),     32'd0);
    chk("rst.Cout",  32'(cout),  32'd0);
    chk("rst.Ovf",   32'(ovf),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle.Ready", 32'(ready), 32'd1);
    chk("idle.Done",  32'(done),  32'd0);

    // Directed vectors.
    run_op("basic",  16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_p",  16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op("ovf_n",  16'h8000, 16'h8000, 1'b0, 1'b0);
    run_op("zero",   16'h0000, 16'h0000, 1'b0, 1'b0);
    run_op("allone", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

    // Random vectors.
    for (int i = 0; i < 24; i++) begin
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      run_op("sub_rand", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end
`endif

    // Start held high; operands toggle during RUN. Only the first request
    // runs; the second is accepted only after DONE returns to IDLE.
    a = 16'hA5C3; b = 16'h1E7F;
    @(negedge clk);
    x = a; y = b; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    do begin
      x = W'($urandom); y = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < MAX_LAT);
    chk("hold1.lat", 32'(lat), 32'(NIB));
    check_result("hold1", a, b, 1'b0, 1'b0);
    chk("hold1.ready_in_done", 32'(ready), 32'd0);
    hold_s = s;
    a = 16'h0F0F; b = 16'h00F1;
    x = a; y = b; cin = 1'b1;
    @(posedge clk); #1;
    chk("hold.idle_ready", 32'(ready), 32'd1);
    chk("hold.idle_S", 32'(s), 32'(hold_s));
    @(posedge clk); #1;
    chk("hold2.accepted", 32'(ready), 32'd0);
    start = 1'b0;
    x = W'($urandom); y = W'($urandom);
    seen = 0;
    lat = 0;
    do begin
      if (s !== hold_s) seen++;
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < MAX_LAT);
    chk("hold2.S_stable_in_run", 32'(seen), 32'd0);
    chk("hold2.lat", 32'(lat), 32'(NIB));
    check_result("hold2", a, b, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of RUN aborts without a Done pulse.
    e = model(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    x = 16'h1111; y = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort.Ready", 32'(ready), 32'd1);
    chk("abort.Done",  32'(done),  32'd0);
    chk("abort.S",     32'(s),     32'd0);
    chk("abort.Cout",  32'(cout),  32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort.no_done", 32'(seen), 32'd0);
    chk("abort.S_hold", 32'(s), 32'd0);

    // Normal operation resumes after the abort.
    run_op("post_abort", 16'h1111, 16'h2222, 1'b0, 1'b0);
    chk("post_abort.sum", 32'(s), 32'(e[W-1:0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nibble_serial_adder
